tlul_arbiter_2m1s: RTL and testbench
====================================

TLUL_ARBITER_2M1S -- requirements
Module: tlul_arbiter_2m1s

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 32 (address), DATA_WIDTH 32 (data), MASK_WIDTH DATA_WIDTH/8 (byte mask), SIZE_WIDTH 3, SRC_WIDTH 4 (upstream source), SINK_WIDTH 1, OPCODE_WIDTH 3, PARAM_WIDTH 3, MAX_OUTSTANDING 4 (per-master in-flight limit, 1..15).
REQ-002 clk_100  in  1  single clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mN_a_valid in 1, mN_a_ready out 1, N=0,1  A-channel handshake from master N.
REQ-005 mN_a_opcode/param/size/source/address/mask/data  in  respective widths  A-channel payload of master N.
REQ-006 mN_d_valid out 1, mN_d_ready in 1  D-channel handshake to master N.
REQ-007 mN_d_opcode/param/size/source/sink/data/error  out  respective widths (source SRC_WIDTH, error 1)  D payload to master N.
REQ-008 s_a_valid out 1, s_a_ready in 1, s_a_opcode/param/size/address/mask/data out  A channel to the shared slave.
REQ-009 s_a_source  out  SRC_WIDTH+1  tagged source: MSB = master index, low bits = master source.
REQ-010 s_d_valid in 1, s_d_ready out 1, s_d_opcode/param/size/sink/data/error in, s_d_source in SRC_WIDTH+1  D channel from the slave.
REQ-011 err_unexpected_d  out  1  one-cycle pulse on a D beat for a master with zero outstanding.

Function
REQ-012 A-arbiter FSM SHALL have two states: IDLE, BUSY; registers grant (1 bit) and rr_ptr (1 bit, preferred master).
REQ-013 A master SHALL be eligible when mN_a_valid=1 and its outstanding count < MAX_OUTSTANDING.
REQ-014 In IDLE, if any master is eligible: grant <= rr_ptr if rr_ptr eligible, else the other; state <= BUSY; no handshake in IDLE.
REQ-015 In BUSY: s_a_valid = m[grant]_a_valid; s_a_* payload = m[grant] payload; m[grant]_a_ready = s_a_ready; the ungranted master's a_ready = 0.
REQ-016 On A handshake (s_a_valid & s_a_ready in BUSY): state <= IDLE, rr_ptr <= ~grant.
REQ-017 If the granted master drops a_valid in BUSY without handshake (protocol violation), state SHALL return to IDLE with rr_ptr unchanged.
REQ-018 Latency: first s_a_valid one cycle after eligibility; maximum A throughput one beat per two cycles.
REQ-019 In IDLE, s_a_valid = 0 and both mN_a_ready = 0.
REQ-020 D routing SHALL be combinational: i = s_d_source[SRC_WIDTH]; mi_d_valid = s_d_valid; other master's d_valid = 0; s_d_ready = mi_d_ready.
REQ-021 mN_d_source = s_d_source[SRC_WIDTH-1:0]; all other D payload passed unchanged to both masters.
REQ-022 Per-master outstanding counter, width clog2(MAX_OUTSTANDING+1): +1 on that master's A handshake, -1 on its D handshake, unchanged on both in the same cycle.
REQ-023 D handshake for a master with count 0: beat still forwarded, counter held at 0, err_unexpected_d = 1 for that cycle (registered, visible next cycle).
REQ-024 Counter at MAX_OUTSTANDING SHALL block that master's eligibility; a simultaneous D handshake that cycle does not re-enable it before the next cycle.
REQ-025 No combinational path from mN_a_valid to s_a_valid except through the registered grant/state.

Reset
REQ-026 While reset=1: state=IDLE, grant=0, rr_ptr=0, counters=0, err_unexpected_d=0, s_a_valid=0, mN_a_ready=0, s_d_ready=0, mN_d_valid=0.
REQ-027 Reset asserted mid-transfer SHALL abandon the granted beat and clear all in-flight accounting on the next edge.

Verification
REQ-028 Single Get: m0 opcode 4, addr 0x1000, size 2, source 3, s_a_ready=1 -> s_a_valid one cycle later, s_a_source=5'h03; D with source 5'h03 -> m0_d_valid, m0_d_source=4'h3, m0 count 1->0.
REQ-029 Both masters valid continuously, s_a_ready=1 -> grants alternate m0,m1,m0,m1; s_a_source MSB alternates 0,1.
REQ-030 m1 issues 4 requests with no D responses -> 5th not granted, m1_a_ready stays 0; one D to source 5'h1x -> 5th granted within 2 cycles.
REQ-031 s_a_ready held 0 for 5 cycles in BUSY -> grant and payload stable; m0 arriving meanwhile not granted until handshake.
REQ-032 D beat source 5'h10 with m1 count 0 -> m1_d_valid=1, err_unexpected_d pulses once, count stays 0.
REQ-033 reset asserted during BUSY with s_a_ready=0 -> next cycle s_a_valid=0, counters 0, rr_ptr=0.

Source files
------------

// File: rtl/tlul_arbiter_2m1s.sv
// tlul_arbiter_2m1s
// Two TL-UL masters share one slave. The A channel is granted round-robin
// through a two-state arbiter (IDLE grants, BUSY presents the beat). The D
// channel is routed combinationally, using the master index that was tagged
// onto the MSB of the slave-side source.
//
// Ports
//   clk_100, reset            : clock and synchronous active-high reset
//   m0_a_* / m1_a_*           : A channel from masters 0 and 1 (valid/ready + payload)
//   m0_d_* / m1_d_*           : D channel to masters 0 and 1 (valid/ready + payload)
//   s_a_*                     : A channel to the slave; s_a_source = {master, source}
//   s_d_*                     : D channel from the slave
//   err_unexpected_d          : registered pulse, set after a D beat for a master
//                               that had nothing outstanding
//   dbg_state_o, dbg_grant_o,
//   dbg_rr_ptr_o, dbg_cnt0_o,
//   dbg_cnt1_o                : arbiter state, grant, preferred master and
//                               per-master outstanding counts
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. Valid never depends combinationally on ready. The slave-side s_a_valid
// depends only on registered state and the granted master's valid.
module tlul_arbiter_2m1s #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int SRC_WIDTH       = 4,
  parameter int SINK_WIDTH      = 1,
  parameter int OPCODE_WIDTH    = 3,
  parameter int PARAM_WIDTH     = 3,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_100,
  input  logic                    reset,
  // master 0 A
  input  logic                    m0_a_valid,
  output logic                    m0_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m0_a_param,
  input  logic [SIZE_WIDTH-1:0]   m0_a_size,
  input  logic [SRC_WIDTH-1:0]    m0_a_source,
  input  logic [ADDR_WIDTH-1:0]   m0_a_address,
  input  logic [MASK_WIDTH-1:0]   m0_a_mask,
  input  logic [DATA_WIDTH-1:0]   m0_a_data,
  // master 1 A
  input  logic                    m1_a_valid,
  output logic                    m1_a_ready,
  input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
  input  logic [PARAM_WIDTH-1:0]  m1_a_param,
  input  logic [SIZE_WIDTH-1:0]   m1_a_size,
  input  logic [SRC_WIDTH-1:0]    m1_a_source,
  input  logic [ADDR_WIDTH-1:0]   m1_a_address,
  input  logic [MASK_WIDTH-1:0]   m1_a_mask,
  input  logic [DATA_WIDTH-1:0]   m1_a_data,
  // master 0 D
  output logic                    m0_d_valid,
  input  logic                    m0_d_ready,
  output logic [OPCODE_WIDTH-1:0] m0_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m0_d_param,
  output logic [SIZE_WIDTH-1:0]   m0_d_size,
  output logic [SRC_WIDTH-1:0]    m0_d_source,
  output logic [SINK_WIDTH-1:0]   m0_d_sink,
  output logic [DATA_WIDTH-1:0]   m0_d_data,
  output logic                    m0_d_error,
  // master 1 D
  output logic                    m1_d_valid,
  input  logic                    m1_d_ready,
  output logic [OPCODE_WIDTH-1:0] m1_d_opcode,
  output logic [PARAM_WIDTH-1:0]  m1_d_param,
  output logic [SIZE_WIDTH-1:0]   m1_d_size,
  output logic [SRC_WIDTH-1:0]    m1_d_source,
  output logic [SINK_WIDTH-1:0]   m1_d_sink,
  output logic [DATA_WIDTH-1:0]   m1_d_data,
  output logic                    m1_d_error,
  // slave A
  output logic                    s_a_valid,
  input  logic                    s_a_ready,
  output logic [OPCODE_WIDTH-1:0] s_a_opcode,
  output logic [PARAM_WIDTH-1:0]  s_a_param,
  output logic [SIZE_WIDTH-1:0]   s_a_size,
  output logic [SRC_WIDTH:0]      s_a_source,
  output logic [ADDR_WIDTH-1:0]   s_a_address,
  output logic [MASK_WIDTH-1:0]   s_a_mask,
  output logic [DATA_WIDTH-1:0]   s_a_data,
  // slave D
  input  logic                    s_d_valid,
  output logic                    s_d_ready,
  input  logic [OPCODE_WIDTH-1:0] s_d_opcode,
  input  logic [PARAM_WIDTH-1:0]  s_d_param,
  input  logic [SIZE_WIDTH-1:0]   s_d_size,
  input  logic [SRC_WIDTH:0]      s_d_source,
  input  logic [SINK_WIDTH-1:0]   s_d_sink,
  input  logic [DATA_WIDTH-1:0]   s_d_data,
  input  logic                    s_d_error,
  // status / debug
  output logic                    err_unexpected_d,
  output logic                    dbg_state_o,
  output logic                    dbg_grant_o,
  output logic                    dbg_rr_ptr_o,
  output logic [CNT_WIDTH-1:0]    dbg_cnt0_o,
  output logic [CNT_WIDTH-1:0]    dbg_cnt1_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 err_q, err_d;

  logic elig0, elig1, gnt_valid, a_hs, a_hs0, a_hs1;
  logic d_sel, d_hs, d_hs0, d_hs1;

  // Eligibility uses the registered count, so a D beat retiring the last slot
  // only re-enables the master from the following cycle.
  assign elig0     = m0_a_valid && (cnt0_q < CNT_MAX);
  assign elig1     = m1_a_valid && (cnt1_q < CNT_MAX);
  assign gnt_valid = grant_q ? m1_a_valid : m0_a_valid;

  // A-channel mux: only the granted master is visible, and only in BUSY.
  assign s_a_valid   = !reset && (state_q == BUSY) && gnt_valid;
  assign m0_a_ready  = !reset && (state_q == BUSY) && !grant_q && s_a_ready;
  assign m1_a_ready  = !reset && (state_q == BUSY) &&  grant_q && s_a_ready;
  assign s_a_opcode  = grant_q ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = grant_q ? m1_a_param   : m0_a_param;
  assign s_a_size    = grant_q ? m1_a_size    : m0_a_size;
  assign s_a_source  = {grant_q, (grant_q ? m1_a_source : m0_a_source)};
  assign s_a_address = grant_q ? m1_a_address : m0_a_address;
  assign s_a_mask    = grant_q ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = grant_q ? m1_a_data    : m0_a_data;

  assign a_hs  = s_a_valid && s_a_ready;
  assign a_hs0 = a_hs && !grant_q;
  assign a_hs1 = a_hs &&  grant_q;

  // D-channel routing by the tag bit the arbiter put on the request.
  assign d_sel      = s_d_source[SRC_WIDTH];
  assign m0_d_valid = !reset && s_d_valid && !d_sel;
  assign m1_d_valid = !reset && s_d_valid &&  d_sel;
  assign s_d_ready  = !reset && (d_sel ? m1_d_ready : m0_d_ready);
  assign d_hs       = s_d_valid && s_d_ready;
  assign d_hs0      = d_hs && !d_sel;
  assign d_hs1      = d_hs &&  d_sel;

  assign m0_d_opcode = s_d_opcode;
  assign m0_d_param  = s_d_param;
  assign m0_d_size   = s_d_size;
  assign m0_d_source = s_d_source[SRC_WIDTH-1:0];
  assign m0_d_sink   = s_d_sink;
  assign m0_d_data   = s_d_data;
  assign m0_d_error  = s_d_error;
  assign m1_d_opcode = s_d_opcode;
  assign m1_d_param  = s_d_param;
  assign m1_d_size   = s_d_size;
  assign m1_d_source = s_d_source[SRC_WIDTH-1:0];
  assign m1_d_sink   = s_d_sink;
  assign m1_d_data   = s_d_data;
  assign m1_d_error  = s_d_error;

  // Arbiter next state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          state_d = BUSY;
          if (rr_ptr_q ? elig1 : elig0) grant_d = rr_ptr_q;
          else                          grant_d = !rr_ptr_q;
        end
      end
      BUSY: begin
        if (a_hs) begin
          state_d  = IDLE;
          rr_ptr_d = !grant_q;
        end else if (!gnt_valid) begin
          // Granted master withdrew its request: give up the grant and keep
          // the same preference so nobody loses their turn.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding accounting. A D beat at count 0 is forwarded but flagged and
  // the counter stays at 0.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (a_hs0 && !d_hs0)                         cnt0_d = cnt0_q + CNT_ONE;
    else if (d_hs0 && !a_hs0 && cnt0_q != '0)    cnt0_d = cnt0_q - CNT_ONE;
    if (a_hs1 && !d_hs1)                         cnt1_d = cnt1_q + CNT_ONE;
    else if (d_hs1 && !a_hs1 && cnt1_q != '0)    cnt1_d = cnt1_q - CNT_ONE;
    err_d = (d_hs0 && cnt0_q == '0) || (d_hs1 && cnt1_q == '0);
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      err_q    <= err_d;
    end
  end

  assign err_unexpected_d = err_q;
  assign dbg_state_o      = state_q;
  assign dbg_grant_o      = grant_q;
  assign dbg_rr_ptr_o     = rr_ptr_q;
  assign dbg_cnt0_o       = cnt0_q;
  assign dbg_cnt1_o       = cnt1_q;

endmodule

// File: tb/tb_tlul_arbiter_2m1s.sv
// Testbench for tlul_arbiter_2m1s: directed scenarios plus a randomized run
// checked against a behavioural model of the arbitration and accounting rules.
module tb_tlul_arbiter_2m1s;

  localparam int MAXO = 4;

  logic clk_100 = 1'b0;
  logic reset   = 1'b1;

  logic [1:0]  a_valid, a_ready_o, d_ready, d_valid_o;
  logic [2:0]  a_opcode [2], a_param [2], a_size [2];
  logic [3:0]  a_source [2], a_mask [2];
  logic [31:0] a_address [2], a_data [2];

  logic [2:0]  d_opcode_o [2], d_param_o [2], d_size_o [2];
  logic [3:0]  d_source_o [2];
  logic [0:0]  d_sink_o [2];
  logic [31:0] d_data_o [2];
  logic        d_error_o [2];

  logic        s_a_valid, s_a_ready;
  logic [2:0]  s_a_opcode, s_a_param, s_a_size;
  logic [4:0]  s_a_source;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0]  s_a_mask;
  logic        s_d_valid, s_d_ready;
  logic [2:0]  s_d_opcode, s_d_param, s_d_size;
  logic [4:0]  s_d_source;
  logic [0:0]  s_d_sink;
  logic [31:0] s_d_data;
  logic        s_d_error;
  logic        err_unexpected_d;
  logic        dbg_state, dbg_grant, dbg_rr;
  logic [2:0]  dbg_cnt0, dbg_cnt1;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit  m_busy, m_grant, m_rr, m_err;
  int  m_cnt [2];
  logic [4:0] exp_q0 [$];
  logic [4:0] exp_q1 [$];

  tlul_arbiter_2m1s dut (
    .clk_100(clk_100), .reset(reset),
    .m0_a_valid(a_valid[0]), .m0_a_ready(a_ready_o[0]), .m0_a_opcode(a_opcode[0]),
    .m0_a_param(a_param[0]), .m0_a_size(a_size[0]), .m0_a_source(a_source[0]),
    .m0_a_address(a_address[0]), .m0_a_mask(a_mask[0]), .m0_a_data(a_data[0]),
    .m1_a_valid(a_valid[1]), .m1_a_ready(a_ready_o[1]), .m1_a_opcode(a_opcode[1]),
    .m1_a_param(a_param[1]), .m1_a_size(a_size[1]), .m1_a_source(a_source[1]),
    .m1_a_address(a_address[1]), .m1_a_mask(a_mask[1]), .m1_a_data(a_data[1]),
    .m0_d_valid(d_valid_o[0]), .m0_d_ready(d_ready[0]), .m0_d_opcode(d_opcode_o[0]),
    .m0_d_param(d_param_o[0]), .m0_d_size(d_size_o[0]), .m0_d_source(d_source_o[0]),
    .m0_d_sink(d_sink_o[0]), .m0_d_data(d_data_o[0]), .m0_d_error(d_error_o[0]),
    .m1_d_valid(d_valid_o[1]), .m1_d_ready(d_ready[1]), .m1_d_opcode(d_opcode_o[1]),
    .m1_d_param(d_param_o[1]), .m1_d_size(d_size_o[1]), .m1_d_source(d_source_o[1]),
    .m1_d_sink(d_sink_o[1]), .m1_d_data(d_data_o[1]), .m1_d_error(d_error_o[1]),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_sink(s_d_sink), .s_d_data(s_d_data), .s_d_error(s_d_error),
    .err_unexpected_d(err_unexpected_d),
    .dbg_state_o(dbg_state), .dbg_grant_o(dbg_grant), .dbg_rr_ptr_o(dbg_rr),
    .dbg_cnt0_o(dbg_cnt0), .dbg_cnt1_o(dbg_cnt1)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_100 = ~clk_100;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    a_valid = 2'b00; d_ready = 2'b00; s_a_ready = 1'b0; s_d_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      a_opcode[n] = '0; a_param[n] = '0; a_size[n] = '0; a_source[n] = '0;
      a_mask[n] = '0; a_address[n] = '0; a_data[n] = '0;
    end
    s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_source = '0;
    s_d_sink = '0; s_d_data = '0; s_d_error = 1'b0;
  endtask

  task automatic rand_payload(input int n);
    a_opcode[n]  = 3'($urandom_range(0, 7));
    a_param[n]   = 3'($urandom_range(0, 7));
    a_size[n]    = 3'($urandom_range(0, 2));
    a_source[n]  = 4'($urandom_range(0, 15));
    a_mask[n]    = 4'($urandom_range(0, 15));
    a_address[n] = $urandom;
    a_data[n]    = $urandom;
  endtask

  // Advance one clock: the model sees the inputs that the DUT samples at the
  // coming rising edge, and its new state is committed just after that edge.
  task automatic tick();
    bit e [2];
    bit nb, ng, nr, ne, hs_a, hs_d, da, dd;
    int nc [2];
    int dm;
    nb = m_busy; ng = m_grant; nr = m_rr; ne = 1'b0;
    nc[0] = m_cnt[0]; nc[1] = m_cnt[1];
    hs_a = 1'b0; hs_d = 1'b0;
    dm = int'(s_d_source[4]);
    if (reset) begin
      nb = 1'b0; ng = 1'b0; nr = 1'b0; nc[0] = 0; nc[1] = 0;
      exp_q0.delete(); exp_q1.delete();
    end else begin
      for (int n = 0; n < 2; n++) e[n] = a_valid[n] && (m_cnt[n] < MAXO);
      if (!m_busy) begin
        if (e[0] || e[1]) begin
          nb = 1'b1;
          ng = e[m_rr] ? m_rr : !m_rr;
        end
      end else if (!a_valid[m_grant]) begin
        nb = 1'b0;
      end else if (s_a_ready) begin
        nb = 1'b0; nr = !m_grant; hs_a = 1'b1;
        if (m_grant) exp_q1.push_back({1'b1, a_source[1]});
        else         exp_q0.push_back({1'b0, a_source[0]});
      end
      hs_d = s_d_valid && d_ready[dm];
      for (int n = 0; n < 2; n++) begin
        da = hs_a && (int'(m_grant) == n);
        dd = hs_d && (dm == n);
        if (dd && m_cnt[n] == 0) ne = 1'b1;
        if (da && !dd)                      nc[n] = m_cnt[n] + 1;
        else if (dd && !da && m_cnt[n] > 0) nc[n] = m_cnt[n] - 1;
      end
      if (hs_d) begin
        if (dm == 0 && exp_q0.size() > 0 && exp_q0[0] == s_d_source) void'(exp_q0.pop_front());
        if (dm == 1 && exp_q1.size() > 0 && exp_q1[0] == s_d_source) void'(exp_q1.pop_front());
      end
    end
    @(posedge clk_100);
    #1;
    m_busy = nb; m_grant = ng; m_rr = nr; m_err = ne;
    m_cnt[0] = nc[0]; m_cnt[1] = nc[1];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    a_valid = 2'b11; s_a_ready = 1'b1; d_ready = 2'b11;
    s_d_valid = 1'b1; s_d_source = 5'h10;
    tick();
    tick();
    @(negedge clk_100);
    checks++;
    if ({s_a_valid, a_ready_o, d_valid_o, s_d_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got s_a_valid=%b a_ready=%b d_valid=%b s_d_ready=%b, want all 0",
               s_a_valid, a_ready_o, d_valid_o, s_d_ready);
    end
    checks++;
    if ({dbg_state, dbg_grant, dbg_rr, dbg_cnt0, dbg_cnt1, err_unexpected_d} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state: got state=%b grant=%b rr=%b cnt0=%0d cnt1=%0d err=%b, want all 0",
               dbg_state, dbg_grant, dbg_rr, dbg_cnt0, dbg_cnt1, err_unexpected_d);
    end
    do_reset();
  endtask

  task automatic test_single_get();
    logic [31:0] rdata;
    do_reset();
    a_valid[0] = 1'b1; a_opcode[0] = 3'd4; a_address[0] = 32'h1000;
    a_size[0] = 3'd2; a_source[0] = 4'h3; a_mask[0] = 4'hf; s_a_ready = 1'b1;
    @(negedge clk_100);
    checks++;
    if (s_a_valid !== 1'b0) begin
      errors++; $display("FAIL get_idle_no_valid: got s_a_valid=%b want 0", s_a_valid);
    end
    tick();
    @(negedge clk_100);
    checks++;
    if ({s_a_valid, a_ready_o[0], s_a_source, s_a_opcode, s_a_size, s_a_address} !==
        {1'b1, 1'b1, 5'h03, 3'd4, 3'd2, 32'h1000}) begin
      errors++;
      $display("FAIL get_a_beat: got valid=%b ready=%b src=%h op=%0d size=%0d addr=%h, want 1 1 03 4 2 00001000",
               s_a_valid, a_ready_o[0], s_a_source, s_a_opcode, s_a_size, s_a_address);
    end
    tick();
    a_valid[0] = 1'b0;
    @(negedge clk_100);
    checks++;
    if (dbg_cnt0 !== 3'd1) begin
      errors++; $display("FAIL get_count_up: got cnt0=%0d want 1", dbg_cnt0);
    end
    rdata = $urandom;
    s_d_valid = 1'b1; s_d_source = 5'h03; s_d_data = rdata; s_d_opcode = 3'd1; d_ready[0] = 1'b1;
    #1;
    checks++;
    if ({d_valid_o, s_d_ready, d_source_o[0], d_data_o[0], d_opcode_o[0]} !==
        {2'b01, 1'b1, 4'h3, rdata, 3'd1}) begin
      errors++;
      $display("FAIL get_d_route: got d_valid=%b s_d_ready=%b src=%h data=%h op=%0d, want 01 1 3 %h 1",
               d_valid_o, s_d_ready, d_source_o[0], d_data_o[0], d_opcode_o[0], rdata);
    end
    tick();
    s_d_valid = 1'b0;
    @(negedge clk_100);
    checks++;
    if ({dbg_cnt0, err_unexpected_d} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL get_count_down: got cnt0=%0d err=%b want 0 0", dbg_cnt0, err_unexpected_d);
    end
  endtask

  task automatic test_alternation();
    logic got [$];
    do_reset();
    a_valid = 2'b11; s_a_ready = 1'b1;
    a_source[0] = 4'h1; a_source[1] = 4'h2;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_100);
      if (s_a_valid) got.push_back(s_a_source[4]);
      tick();
    end
    a_valid = 2'b00;
    checks++;
    if (got.size() != 6) begin
      errors++; $display("FAIL alt_beat_count: got %0d beats in 12 cycles want 6", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== k[0]) begin
        errors++; $display("FAIL alt_order: beat %0d from master %b want %b", k, got[k], k[0]);
      end
    end
  endtask

  task automatic test_outstanding_limit();
    int hs;
    bit found;
    do_reset();
    a_valid[1] = 1'b1; a_source[1] = 4'h5; s_a_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 20 && hs < 4; c++) begin
      @(negedge clk_100);
      if (s_a_valid && a_ready_o[1]) hs++;
      tick();
    end
    checks++;
    if (hs != 4) begin
      errors++; $display("FAIL limit_first_four: got %0d beats want 4", hs);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_100);
      checks++;
      if ({s_a_valid, a_ready_o[1]} !== 2'b00) begin
        errors++; $display("FAIL limit_blocked: cycle %0d s_a_valid=%b m1_a_ready=%b want 0 0", c, s_a_valid, a_ready_o[1]);
      end
      tick();
    end
    checks++;
    if (dbg_cnt1 !== 3'd4) begin
      errors++; $display("FAIL limit_count: got cnt1=%0d want 4", dbg_cnt1);
    end
    s_d_valid = 1'b1; s_d_source = 5'h15; d_ready[1] = 1'b1;
    tick();
    s_d_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2 && !found; c++) begin
      @(negedge clk_100);
      if (s_a_valid && a_ready_o[1]) found = 1'b1;
      tick();
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL limit_reenable: fifth request not granted within 2 cycles (got 0 want 1)");
    end
    a_valid[1] = 1'b0;
    @(negedge clk_100);
    checks++;
    if (dbg_cnt1 !== 3'd4) begin
      errors++; $display("FAIL limit_refill: got cnt1=%0d want 4", dbg_cnt1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    a_valid[1] = 1'b1; a_address[1] = 32'hCAFE_0010; a_source[1] = 4'h9; s_a_ready = 1'b0;
    tick();
    a_valid[0] = 1'b1; a_address[0] = 32'h0000_0200;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_100);
      checks++;
      if ({s_a_valid, s_a_source, s_a_address, a_ready_o} !== {1'b1, 5'h19, 32'hCAFE_0010, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d valid=%b src=%h addr=%h a_ready=%b want 1 19 cafe0010 00",
                 c, s_a_valid, s_a_source, s_a_address, a_ready_o);
      end
      tick();
    end
    s_a_ready = 1'b1;
    tick();
    a_valid[1] = 1'b0;
    @(negedge clk_100);
    checks++;
    if (s_a_valid !== 1'b0) begin
      errors++; $display("FAIL stall_idle_gap: got s_a_valid=%b want 0", s_a_valid);
    end
    tick();
    @(negedge clk_100);
    checks++;
    if ({s_a_valid, s_a_source[4], s_a_address} !== {1'b1, 1'b0, 32'h0000_0200}) begin
      errors++;
      $display("FAIL stall_next_grant: valid=%b master=%b addr=%h want 1 0 00000200", s_a_valid, s_a_source[4], s_a_address);
    end
    tick();
    a_valid = 2'b00;
  endtask

  task automatic test_unexpected_d();
    do_reset();
    s_d_valid = 1'b1; s_d_source = 5'h10; d_ready[1] = 1'b1;
    @(negedge clk_100);
    checks++;
    if ({d_valid_o, s_d_ready, err_unexpected_d} !== {2'b10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL unexp_route: d_valid=%b s_d_ready=%b err=%b want 10 1 0", d_valid_o, s_d_ready, err_unexpected_d);
    end
    tick();
    s_d_valid = 1'b0;
    @(negedge clk_100);
    checks++;
    if ({err_unexpected_d, dbg_cnt1} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL unexp_pulse: err=%b cnt1=%0d want 1 0", err_unexpected_d, dbg_cnt1);
    end
    tick();
    @(negedge clk_100);
    checks++;
    if (err_unexpected_d !== 1'b0) begin
      errors++; $display("FAIL unexp_one_cycle: err=%b want 0", err_unexpected_d);
    end
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    a_valid[0] = 1'b1; s_a_ready = 1'b1;
    tick();
    tick();
    a_valid[0] = 1'b0; a_valid[1] = 1'b1; s_a_ready = 1'b0;
    tick();
    @(negedge clk_100);
    checks++;
    if ({s_a_valid, dbg_cnt0, dbg_rr} !== {1'b1, 3'd1, 1'b1}) begin
      errors++; $display("FAIL rstmid_setup: valid=%b cnt0=%0d rr=%b want 1 1 1", s_a_valid, dbg_cnt0, dbg_rr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk_100);
    checks++;
    if ({s_a_valid, dbg_cnt0, dbg_cnt1, dbg_rr, dbg_state} !== {1'b0, 3'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_cleared: valid=%b cnt0=%0d cnt1=%0d rr=%b state=%b want 0 0 0 0 0",
               s_a_valid, dbg_cnt0, dbg_cnt1, dbg_rr, dbg_state);
    end
    tick();
    a_valid = 2'b00;
  endtask

  task automatic test_random();
    bit g;
    bit exp_sav, exp_sdr;
    logic [1:0] exp_ar, exp_dv;
    int dm;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++) begin
        a_valid[n] = ($urandom_range(0, 9) < 7);
        rand_payload(n);
      end
      s_a_ready = $urandom_range(0, 2) != 0;
      d_ready   = 2'($urandom_range(0, 3));
      dm = $urandom_range(0, 1);
      s_d_valid = 1'b0;
      if (dm == 0 && exp_q0.size() > 0 && $urandom_range(0, 1) == 1) begin
        s_d_valid = 1'b1; s_d_source = exp_q0[0];
      end else if (dm == 1 && exp_q1.size() > 0 && $urandom_range(0, 1) == 1) begin
        s_d_valid = 1'b1; s_d_source = exp_q1[0];
      end else if ($urandom_range(0, 19) == 0) begin
        s_d_valid = 1'b1; s_d_source = {dm[0], 4'($urandom_range(0, 15))};
      end
      s_d_data = $urandom; s_d_opcode = 3'($urandom_range(0, 7)); s_d_error = 1'($urandom_range(0, 1));
      s_d_param = 3'($urandom_range(0, 7)); s_d_size = 3'($urandom_range(0, 3)); s_d_sink = 1'($urandom_range(0, 1));

      @(negedge clk_100);
      g       = m_grant;
      exp_sav = m_busy && a_valid[g];
      exp_ar  = !m_busy ? 2'b00 : (g ? {s_a_ready, 1'b0} : {1'b0, s_a_ready});
      exp_dv  = !s_d_valid ? 2'b00 : (s_d_source[4] ? 2'b10 : 2'b01);
      exp_sdr = d_ready[s_d_source[4]];

      checks++;
      if ({s_a_valid, a_ready_o} !== {exp_sav, exp_ar}) begin
        errors++;
        $display("FAIL rnd_a_hs: cycle %0d s_a_valid=%b a_ready=%b want %b %b", c, s_a_valid, a_ready_o, exp_sav, exp_ar);
      end
      if (exp_sav) begin
        checks++;
        if ({s_a_source, s_a_address, s_a_data, s_a_mask, s_a_opcode, s_a_param, s_a_size} !==
            {g, a_source[g], a_address[g], a_data[g], a_mask[g], a_opcode[g], a_param[g], a_size[g]}) begin
          errors++;
          $display("FAIL rnd_a_payload: cycle %0d src=%h addr=%h want src=%h addr=%h",
                   c, s_a_source, s_a_address, {g, a_source[g]}, a_address[g]);
        end
      end
      checks++;
      if ({d_valid_o, s_d_ready} !== {exp_dv, exp_sdr}) begin
        errors++;
        $display("FAIL rnd_d_route: cycle %0d d_valid=%b s_d_ready=%b want %b %b", c, d_valid_o, s_d_ready, exp_dv, exp_sdr);
      end
      checks++;
      if ({d_source_o[0], d_source_o[1], d_data_o[0], d_data_o[1], d_opcode_o[1], d_error_o[0], d_param_o[1], d_size_o[0], d_sink_o[1]} !==
          {s_d_source[3:0], s_d_source[3:0], s_d_data, s_d_data, s_d_opcode, s_d_error, s_d_param, s_d_size, s_d_sink}) begin
        errors++;
        $display("FAIL rnd_d_payload: cycle %0d src0=%h src1=%h data0=%h want src=%h data=%h",
                 c, d_source_o[0], d_source_o[1], d_data_o[0], s_d_source[3:0], s_d_data);
      end
      checks++;
      if ({err_unexpected_d, dbg_cnt0, dbg_cnt1} !== {m_err, 3'(m_cnt[0]), 3'(m_cnt[1])}) begin
        errors++;
        $display("FAIL rnd_accounting: cycle %0d err=%b cnt0=%0d cnt1=%0d want %b %0d %0d",
                 c, err_unexpected_d, dbg_cnt0, dbg_cnt1, m_err, m_cnt[0], m_cnt[1]);
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_get();
    test_alternation();
    test_outstanding_limit();
    test_stall();
    test_unexpected_d();
    test_reset_mid_transfer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
